// File: rtl/mod_quad_seq.sv
// Sequential power-of-4 modular scaler: oData = (iData * 4^iShift) mod iQ.
// One registered quadrupling step per clock, valid/ready handshake on both sides.
module mod_quad_seq #(
  parameter int BITWIDTH = 8,
  parameter int CNTWIDTH = 4
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iValid,
  output logic                oReady,
  input  logic [BITWIDTH-1:0] iData,
  input  logic [BITWIDTH-1:0] iQ,
  input  logic [CNTWIDTH-1:0] iShift,
  output logic                oValid,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oBusy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [BITWIDTH-1:0] acc_q, acc_d;
  logic [BITWIDTH-1:0] q_q, q_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;

  // 4a mod q as two conditional-subtract doublings; each stage stays below q when a < q.
  function automatic logic [BITWIDTH-1:0] quad_step(input logic [BITWIDTH-1:0] a,
                                                    input logic [BITWIDTH-1:0] q);
    logic [BITWIDTH:0] qx;
    logic [BITWIDTH:0] d1;
    logic [BITWIDTH:0] d2;
    qx = {1'b0, q};
    d1 = {a, 1'b0};
    d1 = (d1 >= qx) ? (d1 - qx) : d1;
    d2 = {d1[BITWIDTH-1:0], 1'b0};
    d2 = (d2 >= qx) ? (d2 - qx) : d2;
    return d2[BITWIDTH-1:0];
  endfunction

  // State register
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          state_d = (iShift != '0) ? RUN : DONE;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (cnt_q == CNTWIDTH'(1)) begin
          state_d = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        if (iReady) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values; result register loads only when entering DONE
  always_comb begin
    acc_d  = acc_q;
    q_d    = q_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    case (state_q)
      IDLE: begin
        if (iValid) begin
          acc_d = iData;
          q_d   = iQ;
          cnt_d = iShift;
        end else begin
          acc_d = acc_q;
        end
      end
      RUN: begin
        acc_d = quad_step(acc_q, q_q);
        cnt_d = cnt_q - CNTWIDTH'(1);
      end
      default: acc_d = acc_q;
    endcase
    if ((state_d == DONE) && (state_q != DONE)) begin
      data_d = acc_d;
    end else begin
      data_d = data_q;
    end
  end

  // Output decode from next state so handshake outputs come straight from flops
  always_comb begin
    valid_d = (state_d == DONE);
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge iClk) begin
    if (iRst) begin
      acc_q   <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      q_q     <= q_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign oReady = ready_q;
  assign oValid = valid_q;
  assign oBusy  = busy_q;
  assign oData  = data_q;

endmodule

// File: tb/tb_mod_quad_seq.sv
// Directed scoreboard bench for mod_quad_seq: expected results are queued at
// acceptance and compared when oValid appears, along with latency and handshake.
module tb_mod_quad_seq;

  localparam int BW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          out_ready;
  logic [BW-1:0] in_data;
  logic [BW-1:0] in_q;
  logic [CW-1:0] in_shift;
  logic          out_valid;
  logic          in_ready;
  logic [BW-1:0] out_data;
  logic          out_busy;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [BW-1:0] exp_q[$];

  mod_quad_seq #(.BITWIDTH(BW), .CNTWIDTH(CW)) dut (
    .iClk   (clk),
    .iRst   (rst),
    .iValid (in_valid),
    .oReady (out_ready),
    .iData  (in_data),
    .iQ     (in_q),
    .iShift (in_shift),
    .oValid (out_valid),
    .iReady (in_ready),
    .oData  (out_data),
    .oBusy  (out_busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  function automatic logic [BW-1:0] model(input int x, input int q, input int k);
    longint r;
    r = x % q;
    for (int i = 0; i < k; i++) r = (r * 4) % q;
    return r[BW-1:0];
  endfunction

  // Issue one operand, check latency/result/handshake, then drain with optional backpressure.
  task automatic run_op(input int x, input int q, input int k, input int hold, input bit poke);
    int cyc;
    logic [BW-1:0] expv;
    cyc = 0;
    while (!out_ready && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check("ready_before_issue", 32'(out_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = BW'(x);
    in_q     = BW'(q);
    in_shift = CW'(k);
    @(posedge clk);
    exp_q.push_back(model(x, q, k));
    #1;
    in_valid = 1'b0;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (out_valid || cyc >= 40) break;
      if (poke && cyc < 2) begin
        in_valid = 1'b1;
        in_data  = BW'(x + 17 + cyc);
        in_q     = 8'd200;
        in_shift = 4'd2;
      end else begin
        in_valid = 1'b0;
      end
      cyc++;
    end
    in_valid = 1'b0;
    check("valid_seen", 32'(out_valid), 32'd1);
    check("latency", 32'(cyc), 32'(k));
    expv = exp_q.pop_front();
    check("result", 32'(out_data), 32'(expv));
    check("ready_in_done", 32'(out_ready), 32'd0);
    check("busy_in_done", 32'(out_busy), 32'd1);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_data", 32'(out_data), 32'(expv));
    end
    in_ready = 1'b1;
    @(posedge clk);
    #1;
    in_ready = 1'b0;
    @(negedge clk);
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_ready", 32'(out_ready), 32'd1);
    check("drain_busy", 32'(out_busy), 32'd0);
    check("data_retained", 32'(out_data), 32'(expv));
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_ready = 1'b0;
    in_data  = '0;
    in_q     = 8'd1;
    in_shift = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_ready", 32'(out_ready), 32'd1);
    check("reset_busy", 32'(out_busy), 32'd0);
    check("reset_data", 32'(out_data), 32'd0);

    run_op(3, 13, 1, 0, 1'b0);      // 12
    run_op(3, 13, 2, 0, 1'b0);      // 9
    run_op(5, 13, 0, 0, 1'b0);      // 5
    run_op(250, 251, 3, 0, 1'b0);   // 187
    run_op(0, 1, 5, 0, 1'b0);       // 0
    run_op(7, 11, 2, 4, 1'b0);      // 2 under backpressure
    run_op(1, 255, 15, 0, 1'b1);    // 2^30 mod 255 = 64, with busy-time pokes
    run_op(200, 251, 7, 1, 1'b0);

    // Abort a k=6 operation mid-RUN
    in_valid = 1'b1;
    in_data  = 8'd4;
    in_q     = 8'd29;
    in_shift = 4'd6;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_run_busy", 32'(out_busy), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_valid", 32'(out_valid), 32'd0);
    check("abort_data", 32'(out_data), 32'd0);
    check("abort_ready", 32'(out_ready), 32'd1);
    check("abort_busy", 32'(out_busy), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_result", 32'(out_valid), 32'd0);

    run_op(2, 9, 1, 0, 1'b0);       // 8

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
